// File: rtl/brom_pkg.sv
// brom_pkg: shared widths and FSM encoding for the BROM reader/writer pair
package brom_pkg;
  localparam int DATA_W = 4;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/max_track.sv
// max_track: registered running unsigned maximum with synchronous clear
module max_track #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] max
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) max <= '0;
    else if (clr) max <= '0;
    else if (en && din > max) max <= din;
endmodule

// File: rtl/bram_writer.sv
// bram_writer: streams valid/ready samples into BRAM addresses 0..DEPTH-1
// and tracks the largest value written in the current load.
module bram_writer import brom_pkg::*; #(
  parameter int DATA_W = brom_pkg::DATA_W,
  parameter int DEPTH  = brom_pkg::DEPTH,
  parameter int ADDR_W = brom_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic [DATA_W-1:0] Max
);
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic hs, restart;
  always_comb begin
    s_ready = state == LOAD;
    hs      = s_valid && s_ready;
    restart = start && state != LOAD;
  end
  // the pointer wraps to 0 by itself on the last word since DEPTH is 2**ADDR_W
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_count  <= '0;
    end else begin
      mem_we <= hs;
      if (hs) begin
        mem_addr  <= ptr;
        mem_wdata <= s_data;
        ptr       <= ptr + 1'b1;
        wr_count  <= wr_count + 1'b1;
        if (ptr == ADDR_W'(DEPTH - 1)) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (restart) begin
        state    <= LOAD;
        busy     <= 1'b1;
        done     <= 1'b0;
        ptr      <= '0;
        wr_count <= '0;
      end
    end
  max_track #(.W(DATA_W)) u_max (
    .clk(clk), .rst_n(rst_n), .clr(restart), .en(hs), .din(s_data), .max(Max)
  );
endmodule

// File: tb/tb_bram_writer.sv
// tb_bram_writer: directed stimulus with a write scoreboard and a BRAM image
// used to cross-check the writer's Max against a reader-side maximum.
module tb_bram_writer;
  logic clk = 0, rst_n = 0, start = 0, s_valid = 0;
  logic [3:0] s_data = '0;
  logic s_ready, mem_we, busy, done;
  logic [3:0] mem_addr, mem_wdata, Max;
  logic [4:0] wr_count;
  typedef struct {int addr; int data; int cyc;} wr_t;
  wr_t q[$];
  wr_t e;
  logic [3:0] mem [16];
  int cyc = 0, n_vec = 0, n_err = 0;
  int mstate = 0, mptr = 0, mcnt = 0, mmax = 0;
  bram_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .wr_count(wr_count), .Max(Max)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (mem_we) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr %0d data %0d, expected no write", mem_addr, mem_wdata);
      end else begin
        e = q.pop_front();
        chk("wr_addr", int'(mem_addr), e.addr);
        chk("wr_data", int'(mem_wdata), e.data);
        chk("wr_cycle", cyc, e.cyc);
        mem[mem_addr] = mem_wdata;
      end
    end
  task automatic chk_zero(input string tag);
    chk({tag, "_mem_we"}, int'(mem_we), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_wr_count"}, int'(wr_count), 0);
    chk({tag, "_Max"}, int'(Max), 0);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
  endtask
  // one cycle: check status against the model, drive inputs, advance the model
  task automatic step(input logic v, input int d, input logic st);
    chk("s_ready", int'(s_ready), int'(mstate == 1));
    chk("busy", int'(busy), int'(mstate == 1));
    chk("done", int'(done), int'(mstate == 2));
    chk("wr_count", int'(wr_count), mcnt);
    chk("Max", int'(Max), mmax);
    s_valid = v;
    s_data = 4'(d);
    start = st;
    if (v && mstate == 1) begin
      q.push_back('{mptr, d, cyc + 1});
      mptr = (mptr + 1) % 16;
      mcnt++;
      if (d > mmax) mmax = d;
      if (mcnt == 16) mstate = 2;
    end else if (st && mstate != 1) begin
      mstate = 1;
      mptr = 0;
      mcnt = 0;
      mmax = 0;
    end
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    int gap_vals[4] = '{3, 9, 2, 9};
    int ld_vals[16] = '{4, 12, 0, 7, 12, 3, 11, 1, 12, 2, 5, 6, 8, 9, 10, 0};
    int rmax;
    start = 1;
    s_valid = 1;
    s_data = 4'hA;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    start = 0;
    s_valid = 0;
    // full load 0..15 back to back
    step(0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, i, 0);
    step(0, 0, 0);
    chk("full_done", int'(done), 1);
    chk("full_Max", int'(Max), 15);
    chk("full_wr_count", int'(wr_count), 16);
    chk("full_s_ready", int'(s_ready), 0);
    // restart from DONE
    step(0, 0, 1);
    chk("restart_wr_count", int'(wr_count), 0);
    chk("restart_Max", int'(Max), 0);
    chk("restart_done", int'(done), 0);
    chk("restart_busy", int'(busy), 1);
    // gapped valid with ignored start pulses on the idle cycles
    for (int i = 0; i < 4; i++) begin
      step(1, gap_vals[i], 0);
      step(0, 15, 1);
    end
    chk("gap_wr_count", int'(wr_count), 4);
    chk("gap_Max", int'(Max), 9);
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    step(0, 0, 0);
    chk("gap_done", int'(done), 1);
    chk("gap_final_Max", int'(Max), 9);
    // overrun: 17 samples offered, the 17th (15) must be refused
    step(0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 3, 0);
    step(1, 15, 0);
    step(0, 0, 0);
    chk("ovr_wr_count", int'(wr_count), 16);
    chk("ovr_Max", int'(Max), 3);
    chk("ovr_done", int'(done), 1);
    // asynchronous reset after 5 writes
    step(0, 0, 1);
    for (int i = 1; i <= 5; i++) step(1, i, 0);
    chk("pre_rst_mem_we", int'(mem_we), 1);
    chk("pre_rst_wr_count", int'(wr_count), 5);
    #2 rst_n = 0;
    #1 chk_zero("async_rst");
    mstate = 0;
    mptr = 0;
    mcnt = 0;
    mmax = 0;
    chk("rst_pending", q.size(), 0);
    s_valid = 1;
    @(negedge clk);
    rst_n = 1;
    s_valid = 0;
    step(0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, ld_vals[i], 0);
    step(0, 0, 0);
    rmax = 0;
    for (int i = 0; i < 16; i++) if (int'(mem[i]) > rmax) rmax = int'(mem[i]);
    chk("bram_addr0", int'(mem[0]), 4);
    chk("reader_vs_writer", int'(Max), rmax);
    chk("final_Max", int'(Max), 12);
    repeat (2) @(negedge clk);
    chk("pending_writes", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
